// File: rtl/fpu_pkg.sv
// fpu_pkg: single-precision float types, constants and operand class decode
// shared by the FPU execute cluster (fsqrt, fmul, fsquare).
package fpu_pkg;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } float_t;

  localparam int          F_BIAS = 127;
  localparam int          F_EMAX = 255;
  localparam logic [31:0] F_QNAN = 32'h7FC00000;
  localparam logic [31:0] F_PINF = 32'h7F800000;

  typedef enum logic [1:0] {
    CL_NORM,
    CL_ZERO,
    CL_INF,
    CL_NAN
  } fclass_t;

  // Denormals share the zero encoding (e==0) and are flushed with it.
  function automatic fclass_t classify(input float_t f);
    if (f.e == 8'(F_EMAX))
      return (f.m != '0) ? CL_NAN : CL_INF;
    if (f.e == '0)
      return CL_ZERO;
    return CL_NORM;
  endfunction

  // Biased exponent of a square before normalisation: 2*e - bias.
  function automatic logic [9:0] sq_exp(input logic [7:0] e);
    return {1'b0, e, 1'b0} - 10'(F_BIAS);
  endfunction

endpackage

// File: rtl/fsq_round.sv
// fsq_round: combinational normalise/round/pack of a 24x24 significand
// product into a positive single-precision result with range flags.
module fsq_round
  import fpu_pkg::*;
#(
  parameter bit RND = 1'b1
) (
  input  logic [1:0]  cls,
  input  logic [9:0]  er,
  input  logic [25:0] ptop,
  output logic [31:0] y,
  output logic        ovf,
  output logic        unf
);

  logic signed [9:0] er_n;
  logic signed [9:0] er_f;
  logic [22:0]       man;
  logic              g;
  logic [23:0]       sum;

  // ptop holds product bits [47:22]; only the top bit, mantissa and guard matter.
  always_comb begin
    er_n = $signed(er) + (ptop[25] ? 10'sd1 : 10'sd0);
    man  = ptop[25] ? ptop[24:2] : ptop[23:1];
    g    = ptop[25] ? ptop[1]    : ptop[0];
    sum  = {1'b0, man} + {23'b0, (RND ? g : 1'b0)};
    er_f = sum[23] ? (er_n + 10'sd1) : er_n;
  end

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    unf = 1'b0;
    case (fclass_t'(cls))
      CL_NAN:  y = F_QNAN;
      CL_INF:  y = F_PINF;
      CL_ZERO: y = '0;
      default: begin
        if (er_f >= $signed(10'(F_EMAX))) begin
          y   = F_PINF;
          ovf = 1'b1;
        end else if (er_f <= 10'sd0) begin
          unf = 1'b1;
        end else begin
          y = {1'b0, er_f[7:0], sum[22:0]};
        end
      end
    endcase
  end

endmodule

// File: rtl/fsquare.sv
// fsquare: 3-stage pipelined single-precision square y = x*x with valid/ready
// flow control; denormals flush to zero and the result is always positive.
module fsquare
  import fpu_pkg::*;
#(
  parameter bit RND     = 1'b1,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        x_valid,
  output logic        x_ready,
  input  logic [31:0] x,
  output logic        y_valid,
  input  logic        y_ready,
  output logic [31:0] y,
  output logic        y_ovf,
  output logic        y_unf
);

  if (LATENCY != 3) begin : g_latency_check
    $error("fsquare only supports LATENCY = 3");
  end

  logic        v1, v2, v3;
  logic        adv1, adv2, adv3;
  fclass_t     cls1, cls2;
  logic [9:0]  er1, er2;
  logic [22:0] m1;
  logic [23:0] sig1;
  logic [25:0] p2;
  logic [31:0] ry;
  logic        rovf, runf;

  // A stage may load whenever the stage after it is empty or draining.
  assign adv3    = y_ready;
  assign adv2    = ~v3 | adv3;
  assign adv1    = ~v2 | adv2;
  assign x_ready = ~v1 | adv1;
  assign y_valid = v3;
  assign sig1    = {1'b1, m1};

  fsq_round #(
    .RND (RND)
  ) u_round (
    .cls  (cls2),
    .er   (er2),
    .ptop (p2),
    .y    (ry),
    .ovf  (rovf),
    .unf  (runf)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      y     <= '0;
      y_ovf <= 1'b0;
      y_unf <= 1'b0;
    end else begin
      if (x_ready) begin
        v1 <= x_valid;
        if (x_valid) begin
          cls1 <= classify(x);
          er1  <= sq_exp(x[30:23]);
          m1   <= x[22:0];
        end
      end
      // Only product bits [47:22] feed rounding, so the rest is never stored.
      if (adv1) begin
        v2 <= v1;
        if (v1) begin
          cls2 <= cls1;
          er2  <= er1;
          p2   <= 26'(({24'b0, sig1} * {24'b0, sig1}) >> 22);
        end
      end
      if (adv2) begin
        v3 <= v2;
        if (v2) begin
          y     <= ry;
          y_ovf <= rovf;
          y_unf <= runf;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsquare.sv
// tb_fsquare: directed vectors for fsquare with a result scoreboard,
// backpressure streaming and a mid-flight reset.
module tb_fsquare;

  logic        clk;
  logic        rstn;
  logic        x_valid;
  logic        x_ready;
  logic [31:0] x;
  logic        y_valid;
  logic        y_ready;
  logic [31:0] y;
  logic        y_ovf;
  logic        y_unf;

  typedef struct packed {
    logic [33:0] r;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_exp;
  exp_t got;
  int   compared   = 0;
  int   mismatched = 0;
  int   delivered  = 0;

  localparam int NVEC = 15;

  // Operand, hand-computed result and {ovf,unf} flags.
  logic [31:0] vec_x [NVEC] = '{
    32'h40400000, 32'hC0000000, 32'h3FC00000, 32'h3F800001, 32'h3F800800,
    32'h3FB504F3, 32'h7F800000, 32'hFF800001, 32'h00400000, 32'h5F800000,
    32'h1F800000, 32'h1FB504F3, 32'h20000000, 32'h5F7FFFFF, 32'h7F7FFFFF
  };
  logic [31:0] vec_y [NVEC] = '{
    32'h41100000, 32'h40800000, 32'h40100000, 32'h3F800002, 32'h3F801001,
    32'h3FFFFFFF, 32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h7F800000,
    32'h00000000, 32'h00000000, 32'h00800000, 32'h7F7FFFFE, 32'h7F800000
  };
  logic [1:0] vec_f [NVEC] = '{
    2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
    2'b00, 2'b00, 2'b00, 2'b00, 2'b10,
    2'b01, 2'b01, 2'b00, 2'b00, 2'b10
  };

  fsquare dut (
    .clk     (clk),
    .rstn    (rstn),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .x       (x),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y       (y),
    .y_ovf   (y_ovf),
    .y_unf   (y_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [33:0] actual,
                             input logic [33:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%09h, want 0x%09h", tag, actual, expected);
    end
  endtask

  // Sends one operand into an idle pipeline and measures cycles to y_valid.
  task automatic applyStimulus(input logic [31:0] xin, input logic [33:0] want,
                               input int id);
    int lat;
    @(negedge clk);
    x       = xin;
    x_valid = 1'b1;
    cur_exp = '{r: want, id: id};
    lat     = 0;
    do begin
      @(negedge clk);
      x_valid = 1'b0;
      lat++;
      #2;
    end while (!y_valid && lat < 10);
    checkOutput($sformatf("latency#%0d", id), 34'(lat), 34'd3);
    @(negedge clk);
  endtask

  // Scoreboard: handshakes are judged just after the negedge, ahead of the posedge that completes them.
  always @(negedge clk) begin
    #1;
    if (!rstn) begin
      exp_q.delete();
    end else begin
      checkOutput("x_ready", {33'b0, x_ready}, {33'b0, !(exp_q.size() == 3 && !y_ready)});
      if (y_valid && y_ready) begin
        delivered++;
        checkOutput("result_pending", {33'b0, exp_q.size() != 0}, 34'd1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          checkOutput($sformatf("result#%0d", got.id), {y, y_ovf, y_unf}, got.r);
        end
      end
      if (x_valid && x_ready)
        exp_q.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    int k;
    int target;

    rstn    = 1'b0;
    x_valid = 1'b0;
    x       = '0;
    y_ready = 1'b1;
    cur_exp = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #2;
    checkOutput("reset_y_valid", {33'b0, y_valid}, 34'd0);
    checkOutput("reset_y", {y, y_ovf, y_unf}, 34'd0);

    for (int i = 0; i < NVEC; i++)
      applyStimulus(vec_x[i], {vec_y[i], vec_f[i]}, i);

    // Eight back-to-back operands against a 1,0,0 y_ready pattern.
    $display("[TB] streaming with backpressure");
    sent   = 0;
    k      = 0;
    target = delivered + 8;
    while ((sent < 8 || delivered < target) && k < 200) begin
      @(negedge clk);
      y_ready = (k % 3 == 0);
      if (sent < 8) begin
        x       = vec_x[sent];
        x_valid = 1'b1;
        cur_exp = '{r: {vec_y[sent], vec_f[sent]}, id: 50 + sent};
      end else begin
        x_valid = 1'b0;
      end
      #2;
      if (x_valid && x_ready)
        sent++;
      k++;
    end
    checkOutput("stream_sent", 34'(sent), 34'd8);
    checkOutput("stream_delivered", 34'(delivered), 34'(target));
    @(negedge clk);
    x_valid = 1'b0;
    y_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Fill all three stages with the output stalled, then reset.
    $display("[TB] reset with ops in flight");
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      x       = vec_x[i];
      x_valid = 1'b1;
      cur_exp = '{r: {vec_y[i], vec_f[i]}, id: 100 + i};
    end
    @(negedge clk);
    x_valid = 1'b0;
    #2;
    checkOutput("full_x_ready", {33'b0, x_ready}, 34'd0);
    checkOutput("full_y_valid", {33'b0, y_valid}, 34'd1);
    checkOutput("full_y", {y, y_ovf, y_unf}, {vec_y[0], vec_f[0]});
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn    = 1'b1;
    y_ready = 1'b1;
    #2;
    checkOutput("post_reset_y_valid", {33'b0, y_valid}, 34'd0);
    checkOutput("post_reset_y", {y, y_ovf, y_unf}, 34'd0);
    repeat (4) @(negedge clk);
    applyStimulus(vec_x[0], {vec_y[0], vec_f[0]}, 200);
    applyStimulus(vec_x[9], {vec_y[9], vec_f[9]}, 201);

    repeat (2) @(negedge clk);
    checkOutput("drained", 34'(exp_q.size()), 34'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
